// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader and its skid buffer.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam int unsigned SkidDepth = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO-ordered skid buffer; head entry is presented directly from a register.
module stream_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [Width-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop_eff;

  assign pop_eff = pop && (cnt_q != 2'd0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clr) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = 2'd0;
    end else begin
      case ({push, pop_eff})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_d = push_data;
            cnt_d  = 2'd1;
          end else if (cnt_q == 2'd1) begin
            tail_d = push_data;
            cnt_d  = 2'd2;
          end
        end
        2'b01: begin
          if (cnt_q == 2'(SkidDepth)) head_d = tail_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_d = push_data;
          end else begin
            head_d = tail_q;
            tail_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = (cnt_q != 2'd0);
  assign count      = cnt_q;

  // Upstream credit logic must never push into a full buffer without a pop.
  assert property (@(posedge clk) disable iff (!rstn)
                   !(push && !clr && !pop_eff && (cnt_q == 2'(SkidDepth))))
    else $error("stream_skid_buf overflow");

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side engine: credit-based read strobes, skid buffering, packet framing, flush.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned FBITS = 8,
  parameter int unsigned PKT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             flush,
  input  logic [PKT_W-1:0] pkt_len,
  input  logic             fifo_empty,
  input  logic [FBITS-1:0] fifo_dout,
  input  logic             fifo_dout_valid,
  output logic             fifo_rd,
  output logic             fifo_clr,
  output logic [FBITS-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [PKT_W-1:0] beat_cnt
);

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic             inflight_q;
  logic [PKT_W-1:0] beat_q, beat_d;
  logic [PKT_W-1:0] plen_q, plen_d, plen_eff;
  logic [1:0]       buf_cnt;
  logic             buf_valid, pop, push;
  logic [2:0]       credit;

  stream_skid_buf #(
    .Width (FBITS)
  ) u_skid (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (flush),
    .push       (push),
    .push_data  (fifo_dout),
    .pop        (pop),
    .head_data  (out_data),
    .head_valid (buf_valid),
    .count      (buf_cnt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // FSM next state; flush restarts the two-cycle FLUSH sequence from any state
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (flush) begin
      state_d = StFlush;
      phase_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (en) state_d = StRun;
        StRun:  if (!en && !inflight_q && (buf_cnt == 2'd0)) state_d = StIdle;
        StFlush: begin
          if (phase_q) begin
            state_d = en ? StRun : StIdle;
            phase_d = 1'b0;
          end else begin
            phase_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    pop      = buf_valid && out_ready;
    credit   = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd  = (state_q == StRun) && en && !fifo_empty && !flush && (credit < 3'd2);
    fifo_clr = (state_q == StFlush) && !phase_q;
    // Words arriving during or at the start of a flush are stale.
    push     = fifo_dout_valid && !flush && (state_q != StFlush);
    busy     = inflight_q || (buf_cnt != 2'd0) || (state_q == StFlush);
  end

  // Packet length is sampled continuously while at beat 0, then frozen for the packet.
  always_comb begin
    if (beat_q == '0) begin
      plen_eff = (pkt_len == '0) ? PKT_W'(1) : pkt_len;
    end else begin
      plen_eff = plen_q;
    end
    plen_d   = plen_eff;
    out_last = buf_valid && (beat_q == plen_eff - PKT_W'(1));
    beat_d   = beat_q;
    if (flush) begin
      beat_d = '0;
    end else if (pop) begin
      beat_d = out_last ? '0 : beat_q + PKT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
      plen_q     <= PKT_W'(1);
    end else begin
      inflight_q <= fifo_rd;
      beat_q     <= beat_d;
      plen_q     <= plen_d;
    end
  end

  assign out_valid = buf_valid;
  assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural one-cycle-latency FIFO model.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       en, flush, out_ready;
  logic [7:0] pkt_len;
  logic       fifo_empty, fifo_dout_valid, fifo_rd, fifo_clr;
  logic [7:0] fifo_dout, out_data, beat_cnt;
  logic       out_valid, out_last, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .FBITS (8),
    .PKT_W (8)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .en              (en),
    .flush           (flush),
    .pkt_len         (pkt_len),
    .fifo_empty      (fifo_empty),
    .fifo_dout       (fifo_dout),
    .fifo_dout_valid (fifo_dout_valid),
    .fifo_rd         (fifo_rd),
    .fifo_clr        (fifo_clr),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_last        (out_last),
    .out_ready       (out_ready),
    .busy            (busy),
    .beat_cnt        (beat_cnt)
  );

  // FIFO model: bench writes mem/wr_ptr, model owns rd_ptr
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       model_valid = 1'b0;
  logic [7:0] model_dout = 8'd0;
  logic       inject = 1'b0;
  logic [7:0] inject_data = 8'd0;
  int         rd_empty_viol = 0;

  assign fifo_empty      = (rd_ptr == wr_ptr);
  assign fifo_dout_valid = model_valid | inject;
  assign fifo_dout       = inject ? inject_data : model_dout;

  always @(posedge clk) begin
    if (fifo_rd && fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
    if (fifo_clr) begin
      rd_ptr      <= wr_ptr;
      model_valid <= 1'b0;
    end else if (fifo_rd && !fifo_empty) begin
      model_dout  <= mem[rd_ptr];
      rd_ptr      <= rd_ptr + 8'd1;
      model_valid <= 1'b1;
    end else begin
      model_valid <= 1'b0;
    end
  end

  task automatic load(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  logic       s_rd, s_clr, s_valid, s_last, s_busy, s_ready;
  logic [7:0] s_data, s_beat;
  logic [7:0] dq[$];
  logic       lq[$];

  task automatic cycle();
    @(negedge clk);
    s_rd = fifo_rd; s_clr = fifo_clr; s_valid = out_valid; s_last = out_last;
    s_busy = busy; s_ready = out_ready; s_data = out_data; s_beat = beat_cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n);
    for (int c = 0; c < n; c++) begin
      cycle();
      if (s_valid && s_ready) begin
        dq.push_back(s_data);
        lq.push_back(s_last);
      end
    end
  endtask

  task automatic test_reset();
    en = 1'b0; flush = 1'b0; pkt_len = 8'd3; out_ready = 1'b0;
    #1 rstn = 1'b0;
    #2;
    n_tests++;
    if ({fifo_rd, fifo_clr, out_valid, out_last, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {fifo_rd, fifo_clr, out_valid, out_last, busy});
    end
    n_tests++;
    if (out_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h want 00", out_data);
    end
    n_tests++;
    if (beat_cnt !== 8'h00) begin
      n_fail++; $display("FAIL reset_beat: got %0d want 0", beat_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic [11:0] rd_v, val_v, last_v;
    logic [7:0]  d_v [12];
    rd_v = '0; val_v = '0; last_v = '0;
    load(8'h11); load(8'h22); load(8'h33);
    pkt_len = 8'd3; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      rd_v[i] = s_rd; val_v[i] = s_valid; last_v[i] = s_last; d_v[i] = s_data;
    end
    n_tests++;
    if (rd_v !== 12'h00E) begin
      n_fail++; $display("FAIL basic_rd: got %b want %b", rd_v, 12'h00E);
    end
    n_tests++;
    if (val_v !== 12'h038) begin
      n_fail++; $display("FAIL basic_valid: got %b want %b", val_v, 12'h038);
    end
    n_tests++;
    if (last_v !== 12'h020) begin
      n_fail++; $display("FAIL basic_last: got %b want %b", last_v, 12'h020);
    end
    n_tests++;
    if ({d_v[3], d_v[4], d_v[5]} !== 24'h112233) begin
      n_fail++;
      $display("FAIL basic_data: got %h %h %h want 11 22 33", d_v[3], d_v[4], d_v[5]);
    end
    n_tests++;
    if ((s_beat !== 8'd0) || (s_busy !== 1'b0)) begin
      n_fail++; $display("FAIL basic_end: beat %0d busy %b want 0 0", s_beat, s_busy);
    end
    en = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic check_stream(input string name, input logic [7:0] first, input int n,
                              input logic [31:0] exp_last);
    logic [31:0] lv;
    lv = '0;
    n_tests++;
    if (dq.size() != n) begin
      n_fail++; $display("FAIL %s_count: got %0d want %0d", name, dq.size(), n);
    end
    for (int i = 0; i < dq.size() && i < n; i++) begin
      lv[i] = lq[i];
      n_tests++;
      if (dq[i] !== first + 8'(i)) begin
        n_fail++; $display("FAIL %s_data[%0d]: got %h want %h", name, i, dq[i], first + 8'(i));
      end
    end
    n_tests++;
    if (lv !== exp_last) begin
      n_fail++; $display("FAIL %s_last: got %b want %b", name, lv, exp_last);
    end
    dq.delete(); lq.delete();
  endtask

  task automatic test_packets();
    for (int i = 0; i < 8; i++) load(8'h40 + 8'(i));
    pkt_len = 8'd3; en = 1'b1; out_ready = 1'b1;
    collect(20);
    check_stream("pkt3", 8'h40, 8, 32'b0010_0100);
    n_tests++;
    if (s_beat !== 8'd2) begin
      n_fail++; $display("FAIL pkt3_beat: got %0d want 2", s_beat);
    end
    // Length change lands mid-packet: first word still closes the 3-beat packet.
    pkt_len = 8'd0;
    for (int i = 0; i < 5; i++) load(8'h50 + 8'(i));
    collect(16);
    check_stream("pkt0", 8'h50, 5, 32'b1_1111);
    n_tests++;
    if (s_beat !== 8'd0) begin
      n_fail++; $display("FAIL pkt0_beat: got %0d want 0", s_beat);
    end
    en = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_backpressure();
    int         rd_cnt;
    logic [7:0] held;
    rd_cnt = 0;
    for (int i = 0; i < 6; i++) load(8'h60 + 8'(i));
    pkt_len = 8'd8; en = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10 && dq.size() == 0; c++) collect(1);
    out_ready = 1'b0;
    cycle();
    held = s_data;
    rd_cnt += int'(s_rd);
    n_tests++;
    if ((s_valid !== 1'b1) || (held !== 8'h61)) begin
      n_fail++; $display("FAIL bp_head: valid %b data %h want 1 61", s_valid, held);
    end
    for (int c = 0; c < 4; c++) begin
      cycle();
      rd_cnt += int'(s_rd);
      n_tests++;
      if ((s_valid !== 1'b1) || (s_data !== held)) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid %b data %h want 1 %h", c, s_valid, s_data, held);
      end
    end
    n_tests++;
    if (rd_cnt > 2) begin
      n_fail++; $display("FAIL bp_reads: got %0d want <=2", rd_cnt);
    end
    out_ready = 1'b1;
    collect(20);
    check_stream("bp", 8'h60, 6, 32'b0);
    en = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_flush();
    int clr_cnt;
    clr_cnt = 0;
    for (int i = 0; i < 6; i++) load(8'h70 + 8'(i));
    pkt_len = 8'd4; en = 1'b1; out_ready = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    cycle();
    n_tests++;
    if ((s_rd !== 1'b1) || (s_valid !== 1'b1)) begin
      n_fail++; $display("FAIL flush_pre: rd %b valid %b want 1 1", s_rd, s_valid);
    end
    out_ready = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    clr_cnt += int'(s_clr);
    n_tests++;
    if ({s_clr, s_valid, s_rd, s_busy} !== 4'b1001 || s_beat !== 8'd0) begin
      n_fail++;
      $display("FAIL flush_first: clr/valid/rd/busy %b beat %0d want 1001 0",
               {s_clr, s_valid, s_rd, s_busy}, s_beat);
    end
    inject = 1'b1; inject_data = 8'hEE;
    cycle();
    clr_cnt += int'(s_clr);
    n_tests++;
    if ({s_clr, s_busy} !== 2'b01) begin
      n_fail++; $display("FAIL flush_second: clr/busy %b want 01", {s_clr, s_busy});
    end
    inject = 1'b0;
    cycle();
    clr_cnt += int'(s_clr);
    n_tests++;
    if ({s_valid, s_busy} !== 2'b00) begin
      n_fail++; $display("FAIL flush_after: valid/busy %b want 00", {s_valid, s_busy});
    end
    for (int i = 0; i < 4; i++) load(8'h81 + 8'(i));
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      collect(1);
      clr_cnt += int'(s_clr);
    end
    check_stream("flush_resume", 8'h81, 4, 32'b1000);
    n_tests++;
    if (clr_cnt != 1) begin
      n_fail++; $display("FAIL flush_clr_cycles: got %0d want 1", clr_cnt);
    end
    n_tests++;
    if (s_beat !== 8'd0) begin
      n_fail++; $display("FAIL flush_beat: got %0d want 0", s_beat);
    end
  endtask

  task automatic test_empty_gap();
    pkt_len = 8'd5; en = 1'b1; out_ready = 1'b1;
    load(8'h91); load(8'h92);
    collect(10);
    n_tests++;
    if ((s_beat !== 8'd2) || (s_valid !== 1'b0)) begin
      n_fail++; $display("FAIL gap_mid: beat %0d valid %b want 2 0", s_beat, s_valid);
    end
    load(8'h93); load(8'h94); load(8'h95);
    collect(10);
    check_stream("gap", 8'h91, 5, 32'b1_0000);
    n_tests++;
    if (rd_empty_viol != 0) begin
      n_fail++; $display("FAIL gap_rd_empty: got %0d want 0", rd_empty_viol);
    end
    n_tests++;
    if (s_beat !== 8'd0) begin
      n_fail++; $display("FAIL gap_beat: got %0d want 0", s_beat);
    end
    en = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_async_reset();
    logic [7:0]  head;
    int          remain;
    logic [31:0] exp_last;
    for (int i = 0; i < 8; i++) load(8'hA0 + 8'(i));
    pkt_len = 8'd2; en = 1'b1; out_ready = 1'b1;
    collect(4);
    dq.delete(); lq.delete();
    n_tests++;
    if (s_busy !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre_busy: got %b want 1", s_busy);
    end
    #1 rstn = 1'b0;
    #1;
    n_tests++;
    if ({fifo_rd, fifo_clr, out_valid, out_last, busy} !== 5'b0 ||
        out_data !== 8'h00 || beat_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL arst_outputs: ctrl %b data %h beat %0d want 00000 00 0",
               {fifo_rd, fifo_clr, out_valid, out_last, busy}, out_data, beat_cnt);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    head   = mem[rd_ptr];
    remain = int'(8'(wr_ptr - rd_ptr));
    exp_last = '0;
    for (int i = 1; i < remain; i += 2) exp_last[i] = 1'b1;
    collect(20);
    check_stream("arst", head, remain, exp_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_packets();
    test_backpressure();
    test_flush();
    test_empty_gap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Reader-side engine for the synchronous FIFO. It issues single-cycle FIFO read strobes, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents the words on a valid/ready output stream with packet framing (out_last every pkt_len beats). It sits between the FIFO's read port and any downstream consumer, such as a serializer or AHB master, and also owns FIFO clear sequencing.

Parameters:
FBITS, 8, FIFO word width and output data width
PKT_W, 8, width of the packet length and beat counter

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  enable reading; 0 = no new FIFO reads issued, buffered words still drain
flush  in  1  single-cycle request: clear FIFO, skid buffer and packet counter
pkt_len  in  PKT_W  beats per packet; 0 is treated as 1
fifo_empty  in  1  FIFO empty flag (combinational from FIFO pointers)
fifo_dout  in  FBITS  FIFO read data
fifo_dout_valid  in  1  FIFO read data valid, one cycle after an accepted read
fifo_rd  out  1  FIFO read strobe
fifo_clr  out  1  FIFO synchronous clear
out_data  out  FBITS  stream data
out_valid  out  1  stream valid
out_last  out  1  final beat of the current packet
out_ready  in  1  downstream accept
busy  out  1  word in flight or buffered, or flush in progress
beat_cnt  out  PKT_W  beats accepted in the current packet

Behaviour:
- Reset (rstn=0, asynchronous): fifo_rd=0, fifo_clr=0, out_valid=0, out_last=0, out_data=0, busy=0, beat_cnt=0, buffer empty, inflight=0, state IDLE.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE goes to RUN when en=1.
  - RUN goes to IDLE when en=0 and inflight=0 and buf_cnt=0.
  - Any state goes to FLUSH on flush=1; flush has priority over all other events.
  - FLUSH lasts 2 cycles, then goes to RUN if en=1, otherwise IDLE.
- Read issue (combinational fifo_rd):
  - fifo_rd = (state==RUN) & en & !fifo_empty & !flush & ((buf_cnt + inflight - pop) < 2).
  - pop = out_valid & out_ready.
  - inflight <= fifo_rd.
  - Full throughput: one word per cycle while out_ready=1 and the FIFO is non-empty.
- Latency: a word read at cycle n is captured on fifo_dout_valid at n+1 and is visible as out_valid at n+2 (registered output).
- Skid buffer:
  - 2 entries, FIFO order. out_data/out_valid always reflect the head entry.
  - Push on fifo_dout_valid and pop in the same cycle are both honoured.
  - fifo_dout_valid with buf_cnt=2 and no pop must never happen; flag it with an assertion.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- Packet framing:
  - Current length plen is latched from pkt_len when beat_cnt==0. A value of 0 is latched as 1.
  - out_last = out_valid & (beat_cnt == plen-1).
  - On pop: beat_cnt wraps to 0 if out_last, otherwise increments.
  - A pkt_len change mid-packet has no effect until the next packet.
- FLUSH:
  - First cycle: fifo_clr=1, fifo_rd=0, out_valid=0, buffer emptied, beat_cnt=0.
  - Second cycle: fifo_dout_valid is ignored, since it may be a stale inflight word.
  - busy=1 throughout.
  - A flush arriving while in FLUSH restarts the 2-cycle sequence.
- en deassertion mid-packet: no new reads, buffered and inflight words still drain. The packet counter is not reset.
- fifo_empty asserted with fifo_rd: the FIFO would ignore the read, so fifo_rd is gated by !fifo_empty as above.

Decomposition:
- Shared package holds state encoding constants (ST_IDLE=0, ST_RUN=1, ST_FLUSH=2) and SKID_DEPTH=2.
- One sub-module, stream_skid_buf: 2-entry buffer with push/pop/count, reusable by the writer side.
- FSM, credit logic and packet counter stay in the top module.

Test Plan:
- Reset then en=1, FIFO preloaded with 0x11,0x22,0x33, out_ready=1 -> fifo_rd high 3 consecutive cycles; out_data 0x11,0x22,0x33 on consecutive cycles, first 2 cycles after the first fifo_rd.
- 8 words, pkt_len=3, out_ready=1 -> out_last on beats 3, 6; beat_cnt ends at 2; pkt_len=0 run -> out_last on every beat.
- out_ready=0 for 5 cycles mid-stream, FIFO holding 6 words -> at most 2 reads issued after stall start; out_data stable; no word lost or duplicated after release (sequence check).
- flush pulse while buf_cnt=2 and a read in flight -> fifo_clr=1 for exactly 1 cycle; out_valid=0 next cycle; stale fifo_dout_valid dropped; beat_cnt=0; resumes RUN with en=1.
- FIFO empties mid-packet, then refills -> fifo_rd never asserted while fifo_empty=1; packet completes correctly across the gap.
- rstn asserted asynchronously mid-transfer (between clock edges) -> all outputs 0 immediately; after release with en=1, streaming restarts from the current FIFO head.
